// File: rtl/dcache_if.sv
// CPU-side and memory-side signals of the direct-mapped data cache controller.
// The slave modport is the controller's view; the master modport is the pipeline/memory side.
interface dcache_if #(
  parameter int unsigned ADDR_W = 32
);
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 256;

  logic               cpu_req_i;
  logic               cpu_write_i;
  logic [ADDR_W-1:0]  cpu_addr_i;
  logic [WORD_W-1:0]  cpu_data_i;
  logic [WORD_W-1:0]  cpu_data_o;
  logic               cpu_stall_o;

  logic               mem_enable_o;
  logic               mem_write_o;
  logic [ADDR_W-1:0]  mem_addr_o;
  logic [BLOCK_W-1:0] mem_data_o;
  logic [BLOCK_W-1:0] mem_data_i;
  logic               mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache controller for the MEM stage.
// Hits are served combinationally; misses stall the pipeline through WRITEBACK/FETCH/FILL.
module dcache_controller #(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned MEM_ADDR_W = 32
) (
  input  logic    clk_i,
  input  logic    rst_i,
  dcache_if.slave bus
);
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 256;
  localparam int unsigned OFF_W   = 5;
  localparam int unsigned IDX_W   = $clog2(NUM_LINES);
  localparam int unsigned TAG_W   = MEM_ADDR_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILL} state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [BLOCK_W-1:0]   data_q [NUM_LINES];

  logic [IDX_W-1:0]     cpu_idx;
  logic [TAG_W-1:0]     cpu_tag;
  logic [2:0]           cpu_word;
  logic                 hit_c;
  logic                 store_hit;
  logic                 fill_en;
  logic                 unused_addr_bits;

  assign cpu_idx          = bus.cpu_addr_i[OFF_W +: IDX_W];
  assign cpu_tag          = bus.cpu_addr_i[MEM_ADDR_W-1 -: TAG_W];
  assign cpu_word         = bus.cpu_addr_i[4:2];
  assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

  assign hit_c = bus.cpu_req_i & valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag);

  // Next state and all outputs; reset forces every output quiet regardless of state.
  always_comb begin
    state_d          = state_q;
    store_hit        = 1'b0;
    fill_en          = 1'b0;
    bus.cpu_data_o   = '0;
    bus.cpu_stall_o  = 1'b0;
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = '0;
    bus.mem_data_o   = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req_i) begin
          if (hit_c) begin
            if (bus.cpu_write_i) store_hit = 1'b1;
            else bus.cpu_data_o = data_q[cpu_idx][{cpu_word, 5'b0} +: WORD_W];
          end else begin
            bus.cpu_stall_o = 1'b1;
            state_d = (valid_q[cpu_idx] & dirty_q[cpu_idx]) ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        bus.cpu_stall_o  = 1'b1;
        bus.mem_enable_o = 1'b1;
        bus.mem_write_o  = 1'b1;
        bus.mem_addr_o   = {tag_q[cpu_idx], cpu_idx, OFF_W'(0)};
        bus.mem_data_o   = data_q[cpu_idx];
        if (bus.mem_ack_i) state_d = FETCH;
      end
      FETCH: begin
        bus.cpu_stall_o  = 1'b1;
        bus.mem_enable_o = 1'b1;
        bus.mem_addr_o   = {cpu_tag, cpu_idx, OFF_W'(0)};
        if (bus.mem_ack_i) begin
          fill_en = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        bus.cpu_stall_o = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!rst_i) begin
      bus.cpu_data_o   = '0;
      bus.cpu_stall_o  = 1'b0;
      bus.mem_enable_o = 1'b0;
      bus.mem_write_o  = 1'b0;
      bus.mem_addr_o   = '0;
      bus.mem_data_o   = '0;
    end
  end

  // State and line status bits; reset aborts any transfer in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_en) begin
        valid_q[cpu_idx] <= 1'b1;
        dirty_q[cpu_idx] <= 1'b0;
      end else if (store_hit) begin
        dirty_q[cpu_idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; valid gates every use of them.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_q[cpu_idx]  <= cpu_tag;
      data_q[cpu_idx] <= bus.mem_data_i;
    end else if (store_hit) begin
      data_q[cpu_idx][{cpu_word, 5'b0} +: WORD_W] <= bus.cpu_data_i;
    end
  end
endmodule
